// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the instruction/data SRAM arbiter: owner encoding and bus widths.
// The round-robin build option is selected with SRAM_ARB_RR_EN.
package sram_arbiter_pkg;

  localparam int WSTRB_W = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Flattened bus widths for a 32-bit address/data build: req, (wr, wstrb,) addr, (wdata)
  localparam int INST_REQ_BUS_WD = 1 + 32;
  localparam int DATA_REQ_BUS_WD = 1 + 1 + WSTRB_W + 32 + 32;
  localparam int MEM_PORT_BUS_WD = 1 + WSTRB_W + 32 + 32;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant decision between fetch and load/store requesters.
// Fixed data priority by default; round-robin on conflict when SRAM_ARB_RR_EN is defined.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic inst_cancel,
  input  logic data_req,
  input  logic rr_last,
  output logic gnt_inst,
  output logic gnt_data
);

  logic inst_ok;

  // A flush never lets a fetch onto the port, even if it is the lone requester.
  assign inst_ok = inst_req & ~inst_cancel;

`ifdef SRAM_ARB_RR_EN
  // On conflict the side that was not granted last wins.
  assign gnt_data = data_req & (~inst_ok | (rr_last == OWNER_INST));
  assign gnt_inst = inst_ok & (~data_req | (rr_last == OWNER_DATA));
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
  assign gnt_data = data_req;
  assign gnt_inst = inst_ok & ~data_req;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous SRAM port between the fetch and load/store requesters.
// Define SRAM_ARB_RR_EN for round-robin arbitration on conflict (default: data priority).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_cancel,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic pick_inst;
  logic pick_data;
  logic gnt_inst;
  logic gnt_data;
  logic rr_last;

  logic vld_p1;
  logic owner_p1;
  logic cancelled_p1;

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= OWNER_INST;
    end else if (gnt_data) begin
      rr_last <= OWNER_DATA;
    end else if (gnt_inst) begin
      rr_last <= OWNER_INST;
    end
  end
`else
  assign rr_last = OWNER_INST;
`endif

  sram_arb_pick u_pick (
    .inst_req    (inst_req),
    .inst_cancel (inst_cancel),
    .data_req    (data_req),
    .rr_last     (rr_last),
    .gnt_inst    (pick_inst),
    .gnt_data    (pick_data)
  );

  // Nothing reaches the port while reset is held.
  assign gnt_inst     = pick_inst & ~reset;
  assign gnt_data     = pick_data & ~reset;
  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_data) begin
      mem_en    = 1'b1;
      mem_wen   = data_wr ? data_wstrb : 4'h0;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (gnt_inst) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end
  end

  // ---- stage p0 -> p1: response owner for the access issued this cycle ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      owner_p1     <= OWNER_INST;
      cancelled_p1 <= 1'b0;
    end else begin
      vld_p1       <= gnt_inst | gnt_data;
      owner_p1     <= gnt_data ? OWNER_DATA : OWNER_INST;
      cancelled_p1 <= gnt_inst & inst_cancel;
    end
  end

  // A late flush swallows the returning fetch word; it is never replayed.
  assign inst_data_ok = vld_p1 & (owner_p1 == OWNER_INST) & ~cancelled_p1 & ~inst_cancel & ~reset;
  assign data_data_ok = vld_p1 & (owner_p1 == OWNER_DATA) & ~reset;
  assign inst_rdata   = reset ? '0 : mem_rdata;
  assign data_rdata   = reset ? '0 : mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter against a cycle-level reference of the arbitration rules.
// Follows SRAM_ARB_RR_EN when the design is built with it.
module tb_sram_arbiter;

  localparam int P_NONE = 0;
  localparam int P_INST = 1;
  localparam int P_DATA = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  int m_pend = P_NONE;
  bit m_rr_data_last = 1'b0;
  bit last_gi, last_gd;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_cancel  (inst_cancel),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    bit ge_i, ge_d, e_iok, e_dok;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wen;
    #2;
    ge_i = 1'b0;
    ge_d = 1'b0;
    if (!reset) begin
`ifdef SRAM_ARB_RR_EN
      if (data_req && inst_req && !inst_cancel) begin
        if (m_rr_data_last) ge_i = 1'b1;
        else                ge_d = 1'b1;
      end else if (data_req) ge_d = 1'b1;
      else if (inst_req && !inst_cancel) ge_i = 1'b1;
`else
      if (data_req) ge_d = 1'b1;
      else if (inst_req && !inst_cancel) ge_i = 1'b1;
`endif
    end
    e_addr  = ge_d ? data_addr : (ge_i ? inst_addr : 32'h0);
    e_wdata = ge_d ? data_wdata : 32'h0;
    e_wen   = (ge_d && data_wr) ? data_wstrb : 4'h0;
    e_iok   = !reset && m_pend == P_INST && !inst_cancel;
    e_dok   = !reset && m_pend == P_DATA;

    chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, ge_i});
    chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, ge_d});
    chk("mem_en", {31'b0, mem_en}, {31'b0, ge_i | ge_d});
    chk("mem_wen", {28'b0, mem_wen}, {28'b0, e_wen});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e_iok});
    chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, e_dok});
    if (e_iok) chk("inst_rdata", inst_rdata, mem_rdata);
    if (e_dok) chk("data_rdata", data_rdata, mem_rdata);

    @(posedge clk);
    if (reset)     m_pend = P_NONE;
    else if (ge_d) m_pend = P_DATA;
    else if (ge_i) m_pend = P_INST;
    else           m_pend = P_NONE;
    if (reset)     m_rr_data_last = 1'b0;
    else if (ge_d) m_rr_data_last = 1'b1;
    else if (ge_i) m_rr_data_last = 1'b0;
    last_gi = ge_i;
    last_gd = ge_d;
    @(negedge clk);
  endtask

  initial begin
    bit i_hold, d_hold;
    reset       = 1'b1;
    inst_req    = 1'b1;
    inst_addr   = 32'h1234_5678;
    inst_cancel = 1'b0;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_wstrb  = 4'hf;
    data_addr   = 32'h0000_0040;
    data_wdata  = 32'h5555_aaaa;
    mem_rdata   = 32'h0;
    @(negedge clk);
    step();
    step();

    // first cycle out of reset, nobody requesting
    reset    = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    step();

    // lone fetch
    inst_req  = 1'b1;
    inst_addr = 32'hbfc0_0000;
    step();
    chk("fetch_granted", {31'b0, last_gi}, 32'd1);
    inst_req  = 1'b0;
    mem_rdata = 32'h2401_0001;
    #1;
    chk("fetch_data_ok", {31'b0, inst_data_ok}, 32'd1);
    chk("fetch_rdata", inst_rdata, 32'h2401_0001);
    step();

    // conflict: store wins, fetch follows
    inst_req   = 1'b1;
    inst_addr  = 32'hbfc0_0004;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h0000_1000;
    data_wstrb = 4'h3;
    data_wdata = 32'hdead_beef;
    #1;
    chk("conflict_store_wen", {28'b0, mem_wen}, 32'h3);
    step();
    data_req = 1'b0;
    data_wr  = 1'b0;
    #1;
    chk("store_done", {31'b0, data_data_ok}, 32'd1);
    chk("fetch_after_store", {31'b0, inst_addr_ok}, 32'd1);
    step();
    inst_req  = 1'b0;
    mem_rdata = 32'h0000_0013;
    #1;
    chk("fetch_after_store_ok", {31'b0, inst_data_ok}, 32'd1);
    step();

    // cancel drops the in-flight fetch and blocks a new one
    inst_req  = 1'b1;
    inst_addr = 32'hbfc0_0100;
    step();
    inst_cancel = 1'b1;
    inst_addr   = 32'hbfc0_0380;
    #1;
    chk("cancel_no_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("cancel_no_grant", {31'b0, inst_addr_ok}, 32'd0);
    step();
    inst_cancel = 1'b0;
    step();
    inst_req  = 1'b0;
    mem_rdata = 32'h3c08_bfc0;
    #1;
    chk("post_cancel_fetch", {31'b0, inst_data_ok}, 32'd1);
    step();

    // reset with a load in flight
    data_req  = 1'b1;
    data_addr = 32'h0000_2000;
    step();
    data_req = 1'b0;
    reset    = 1'b1;
    #1;
    chk("reset_drops_load", {31'b0, data_data_ok}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("after_reset_no_ok", {31'b0, data_data_ok}, 32'd0);
    chk("after_reset_mem_en", {31'b0, mem_en}, 32'd0);
    step();

    // idle
    for (int k = 0; k < 3; k++) step();

    // randomised traffic with hold-until-accepted requesters
    i_hold = 1'b0;
    d_hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!i_hold) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom;
      end
      if (!d_hold) begin
        data_req   = ($urandom_range(0, 1) != 0);
        data_wr    = ($urandom_range(0, 1) != 0);
        data_wstrb = 4'($urandom_range(0, 15));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      inst_cancel = ($urandom_range(0, 6) == 0);
      mem_rdata   = $urandom;
      step();
      i_hold = inst_req && !last_gi && !reset;
      d_hold = data_req && !last_gd && !reset;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
